// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: 640x480@60 VGA timing, 2x2 pixel doubling of an RGB332 front buffer,
// and the vblank-synchronised front/back buffer swap handshake.
module fb_scanout #(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned FB_W    = 320,
  parameter int unsigned FB_H    = 240,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        frame_done,
  output logic        front_sel,
  output logic        fb_rd_en,
  output logic [16:0] fb_addr,
  input  logic [7:0]  fb_dout,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned CW    = 10;
  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = $clog2(PIX_DIV);
  localparam int unsigned H_VIS = 2 * FB_W;
  localparam int unsigned V_VIS = 2 * FB_H;
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
  localparam logic [CW-1:0] V_PRE    = CW'(V_VIS - 1);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [AW-1:0] FB_W_V   = AW'(FB_W);

  typedef enum logic {SHOW = 1'b0, WAIT_VBL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic            front_sel_q, front_sel_d;
  logic            swap_ack_q, swap_ack_d;
  logic            frame_done_q, frame_done_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d;
  logic [3:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic            tick_c, h_wrap_c, visible_c, vbl_start_c, swap_now_c;
  logic [AW-1:0]   fy_c, fx_c, row_base_c;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    front_sel_d  = front_sel_q;
    swap_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    hs1_d        = hs1_q;
    vs1_d        = vs1_q;
    de1_d        = de1_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    vde_d        = vde_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;

    tick_c      = (div_q == DIV_LAST);
    h_wrap_c    = (hcnt_q == H_LAST);
    visible_c   = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    vbl_start_c = tick_c && h_wrap_c && (vcnt_q == V_PRE);

    // Row base address as a sum of shifted copies of fy, one per set bit of FB_W.
    fy_c       = AW'(vcnt_q[CW-1:1]);
    fx_c       = AW'(hcnt_q[CW-1:1]);
    row_base_c = '0;
    for (int i = 0; i < int'(AW); i++) begin
      if (FB_W_V[i]) row_base_c = row_base_c + (fy_c << i);
    end

    div_d = tick_c ? '0 : div_q + DW'(1);

    if (tick_c) begin
      hcnt_d = h_wrap_c ? '0 : hcnt_q + CW'(1);
      if (h_wrap_c) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);

      rd_en_d = visible_c;
      if (visible_c) addr_d = row_base_c + fx_c;

      // Stage 1 captures timing for the position being read; stage 2 meets the BRAM data.
      hs1_d   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs1_d   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      de1_d   = visible_c;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
      vde_d   = de1_q;
      red_d   = de1_q ? {fb_dout[7:5], fb_dout[7]} : 4'h0;
      green_d = de1_q ? {fb_dout[4:2], fb_dout[4]} : 4'h0;
      blue_d  = de1_q ? {fb_dout[1:0], fb_dout[1:0]} : 4'h0;
    end

    // A request arriving on the vblank-start clock is honoured for that same frame.
    swap_now_c   = vbl_start_c && ((state_q == WAIT_VBL) || swap_req);
    frame_done_d = vbl_start_c;
    if (swap_now_c) begin
      front_sel_d = ~front_sel_q;
      swap_ack_d  = 1'b1;
      state_d     = SHOW;
    end else if ((state_q == SHOW) && swap_req) begin
      state_d = WAIT_VBL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW;
      div_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      front_sel_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      de1_q        <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      vde_q        <= 1'b0;
      red_q        <= 4'h0;
      green_q      <= 4'h0;
      blue_q       <= 4'h0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      front_sel_q  <= front_sel_d;
      swap_ack_q   <= swap_ack_d;
      frame_done_q <= frame_done_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      de1_q        <= de1_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      vde_q        <= vde_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign swap_ack   = swap_ack_q;
  assign frame_done = frame_done_q;
  assign front_sel  = front_sel_q;
  assign fb_rd_en   = rd_en_q;
  assign fb_addr    = addr_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vde        = vde_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;

endmodule
